// File: rtl/locking_rr_arbiter.sv
// locking_rr_arbiter
// N_IN-to-1 stream arbiter with a zero-latency datapath. A beat flagged
// in_has_data opens a BEATS-long message. The grant then locks onto that
// channel until the last beat fires, so messages never interleave.
// Unlocked arbitration is round-robin (RR_MODE=1) or fixed lowest-index
// priority (RR_MODE=0).

module locking_rr_arbiter #(
  parameter int N_IN    = 4,
  parameter int DATA_W  = 128,
  parameter int BEATS   = 4,
  parameter int RR_MODE = 1,
  localparam int IW     = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int CW     = $clog2(BEATS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_IN-1:0]        in_valid,
  output logic [N_IN-1:0]        in_ready,
  input  logic [N_IN-1:0]        in_has_data,
  input  logic [N_IN*DATA_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_has_data,
  output logic [DATA_W-1:0]      out_data,
  output logic [IW-1:0]          out_chosen,
  output logic                   out_locked
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  // Counter value of the final beat of a message.
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [IW-1:0]   r_lock_idx;
  logic [IW-1:0]   w_lock_idx_nxt;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   w_rr_ptr_nxt;

  logic [IW-1:0]   w_sel_idx;
  logic            w_found;
  logic [IW-1:0]   w_probe_idx;
  int              w_probe;
  logic [IW-1:0]   w_chosen;
  logic            w_fire;

  // Unlocked selection: search the valids starting just after the
  // round-robin pointer, or from index 0 in fixed-priority mode. With no
  // valid, the first index of the search order is presented.
  always_comb begin
    w_found     = 1'b0;
    w_probe     = 0;
    w_probe_idx = '0;
    if (RR_MODE != 0) begin
      w_sel_idx = IW'((int'(r_rr_ptr) + 1) % N_IN);
      for (int k = 1; k <= N_IN; k++) begin
        w_probe     = (int'(r_rr_ptr) + k) % N_IN;
        w_probe_idx = IW'(w_probe);
        if (!w_found && in_valid[w_probe_idx]) begin
          w_found   = 1'b1;
          w_sel_idx = w_probe_idx;
        end else begin
          w_found   = w_found;
        end
      end
    end else begin
      w_sel_idx = '0;
      for (int k = 0; k < N_IN; k++) begin
        w_probe_idx = IW'(k);
        if (!w_found && in_valid[w_probe_idx]) begin
          w_found   = 1'b1;
          w_sel_idx = w_probe_idx;
        end else begin
          w_found   = w_found;
        end
      end
    end
  end

  // While a message is in flight the lock owner is the only candidate.
  always_comb begin
    if (r_state == ST_LOCKED) begin
      w_chosen = r_lock_idx;
    end else begin
      w_chosen = w_sel_idx;
    end
  end

  // Output mux and per-channel ready; ready ignores the channel's own valid.
  always_comb begin
    out_valid    = 1'b0;
    out_has_data = 1'b0;
    out_data     = '0;
    in_ready     = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_chosen == IW'(i)) begin
        out_valid    = in_valid[i];
        out_has_data = in_has_data[i];
        out_data     = in_data[i*DATA_W +: DATA_W];
        in_ready[i]  = out_ready;
      end else begin
        in_ready[i]  = 1'b0;
      end
    end
  end

  assign out_chosen = w_chosen;
  assign out_locked = (r_state == ST_LOCKED);
  assign w_fire     = out_valid & out_ready;

  // Next-state logic. Only the first beat of a message moves the pointer.
  // Later beats advance the counter and release the lock on the last one.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_lock_idx_nxt = r_lock_idx;
    w_rr_ptr_nxt   = r_rr_ptr;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_fire) begin
          w_rr_ptr_nxt = w_chosen;
          if (out_has_data) begin
            w_state_nxt    = ST_LOCKED;
            w_lock_idx_nxt = w_chosen;
            w_cnt_nxt      = CW'(1);
          end else begin
            w_state_nxt    = ST_UNLOCKED;
          end
        end else begin
          w_rr_ptr_nxt = r_rr_ptr;
        end
      end
      ST_LOCKED: begin
        if (w_fire) begin
          if (r_cnt == LAST_BEAT) begin
            w_state_nxt = ST_UNLOCKED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      default: begin
        w_state_nxt    = ST_UNLOCKED;
        w_cnt_nxt      = '0;
        w_lock_idx_nxt = '0;
        w_rr_ptr_nxt   = IW'(N_IN - 1);
      end
    endcase
  end

  // State registers. The pointer resets to the last channel, so channel 0
  // gets first priority after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_UNLOCKED;
      r_cnt      <= '0;
      r_lock_idx <= '0;
      r_rr_ptr   <= IW'(N_IN - 1);
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_lock_idx <= w_lock_idx_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_locking_rr_arbiter.sv
// Bench for locking_rr_arbiter. It drives a round-robin instance and a
// fixed-priority instance from the same inputs. A behavioural model tracks
// each instance as "message owner plus beats still owed".

module tb_locking_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int B  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_has_data;
  logic [N*DW-1:0] in_data;
  logic          out_ready;

  logic [N-1:0]  act_ready  [2];
  logic          act_valid  [2];
  logic          act_hd     [2];
  logic [DW-1:0] act_data   [2];
  logic [1:0]    act_chosen [2];
  logic          act_locked [2];

  logic [N-1:0]  snap_ready  [2];
  logic          snap_valid  [2];
  logic [1:0]    snap_chosen [2];
  logic          snap_locked [2];

  int checks = 0;
  int passed = 0;

  // Model state per instance: index 0 is round-robin, index 1 is fixed.
  int m_locked [2];
  int m_owner  [2];
  int m_left   [2];
  int m_ptr    [2];

  always #5 clk = ~clk;

  locking_rr_arbiter #(.N_IN(N), .DATA_W(DW), .BEATS(B), .RR_MODE(1)) dut_rr (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(act_ready[0]),
    .in_has_data(in_has_data), .in_data(in_data), .out_valid(act_valid[0]),
    .out_ready(out_ready), .out_has_data(act_hd[0]), .out_data(act_data[0]),
    .out_chosen(act_chosen[0]), .out_locked(act_locked[0])
  );

  locking_rr_arbiter #(.N_IN(N), .DATA_W(DW), .BEATS(B), .RR_MODE(0)) dut_fp (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(act_ready[1]),
    .in_has_data(in_has_data), .in_data(in_data), .out_valid(act_valid[1]),
    .out_ready(out_ready), .out_has_data(act_hd[1]), .out_data(act_data[1]),
    .out_chosen(act_chosen[1]), .out_locked(act_locked[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int exp_chosen(input int m);
    if (m_locked[m] != 0) return m_owner[m];
    if (m == 0) begin
      for (int k = 1; k <= N; k++)
        if (in_valid[(m_ptr[0] + k) % N]) return (m_ptr[0] + k) % N;
      return (m_ptr[0] + 1) % N;
    end
    for (int k = 0; k < N; k++)
      if (in_valid[k]) return k;
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_locked[m] = 0;
      m_owner[m]  = 0;
      m_left[m]   = 0;
      m_ptr[m]    = N - 1;
    end
  endtask

  // One cycle: check all outputs against the model, advance the model,
  // then move on to the next falling edge. Inputs must be stable on entry.
  task automatic step();
    int ec;
    logic f;
    logic [N-1:0] rdy;
    #2;
    for (int m = 0; m < 2; m++) begin
      ec  = exp_chosen(m);
      rdy = out_ready ? (N'(1) << ec) : '0;
      snap_ready[m]  = act_ready[m];
      snap_valid[m]  = act_valid[m];
      snap_chosen[m] = act_chosen[m];
      snap_locked[m] = act_locked[m];
      chk($sformatf("m%0d chosen", m), 64'(act_chosen[m]), 64'(ec));
      chk($sformatf("m%0d valid", m),  64'(act_valid[m]),  64'(in_valid[ec]));
      chk($sformatf("m%0d has_data", m), 64'(act_hd[m]),   64'(in_has_data[ec]));
      chk($sformatf("m%0d data", m),   64'(act_data[m]),   64'(in_data[ec*DW +: DW]));
      chk($sformatf("m%0d in_ready", m), 64'(act_ready[m]), 64'(rdy));
      chk($sformatf("m%0d locked", m), 64'(act_locked[m]), 64'(m_locked[m]));
      f = in_valid[ec] & out_ready;
      if (f) begin
        if (m_locked[m] == 0) begin
          m_ptr[m] = ec;
          if (in_has_data[ec]) begin
            m_locked[m] = 1;
            m_owner[m]  = ec;
            m_left[m]   = B - 1;
          end
        end else begin
          m_left[m] = m_left[m] - 1;
          if (m_left[m] == 0) m_locked[m] = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] hd, input logic rdy);
    in_valid    = v;
    in_has_data = hd;
    out_ready   = rdy;
    for (int w = 0; w < N; w++) in_data[w*DW +: DW] = $urandom;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    chk("reset locked rr", 64'(act_locked[0]), 64'd0);
    chk("reset locked fp", 64'(act_locked[1]), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  logic [1:0] hold_ch;

  initial begin
    reset = 1'b1;
    drive(4'b0000, 4'b0000, 1'b1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // All valid, no messages: plain rotation 0,1,2,3 from reset.
    for (int i = 0; i < 4; i++) begin
      drive(4'b1111, 4'b0000, 1'b1);
      step();
      chk("rotate chosen", 64'(snap_chosen[0]), 64'(i));
    end

    // Channel 2 opens a message while others stay valid.
    drive(4'b0100, 4'b0100, 1'b1);
    step();
    chk("lock2 first chosen", 64'(snap_chosen[0]), 64'd2);
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, 4'b0100, 1'b1);
      step();
      chk("lock2 chosen", 64'(snap_chosen[0]), 64'd2);
      chk("lock2 locked", 64'(snap_locked[0]), 64'd1);
    end
    drive(4'b1111, 4'b0100, 1'b1);
    step();
    chk("after lock2 chosen", 64'(snap_chosen[0]), 64'd3);
    chk("after lock2 locked", 64'(snap_locked[0]), 64'd0);

    // Channel 1 locks, then drops valid for three cycles at beat count 2.
    drive(4'b0010, 4'b0010, 1'b1);
    step();
    drive(4'b0010, 4'b0000, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 4'b0000, 1'b1);
      step();
      chk("stall in_ready", 64'(snap_ready[0]), 64'b0010);
      chk("stall valid", 64'(snap_valid[0]), 64'd0);
      chk("stall locked", 64'(snap_locked[0]), 64'd1);
    end
    for (int i = 0; i < 2; i++) begin
      drive(4'b1111, 4'b0000, 1'b1);
      step();
      chk("resume chosen", 64'(snap_chosen[0]), 64'd1);
    end
    drive(4'b1111, 4'b0000, 1'b1);
    step();
    chk("resume unlocked", 64'(snap_locked[0]), 64'd0);
    chk("resume next", 64'(snap_chosen[0]), 64'd2);

    // Fixed priority picks the lowest valid index.
    for (int i = 0; i < 3; i++) begin
      drive(4'b1010, 4'b0000, 1'b1);
      step();
      chk("fixed 1010", 64'(snap_chosen[1]), 64'd1);
    end
    drive(4'b1000, 4'b0000, 1'b1);
    step();
    chk("fixed 1000", 64'(snap_chosen[1]), 64'd3);

    // Downstream stall: nothing moves for five cycles.
    drive(4'b1111, 4'b0000, 1'b0);
    step();
    hold_ch = snap_chosen[0];
    for (int i = 0; i < 4; i++) begin
      drive(4'b1111, 4'b0000, 1'b0);
      step();
      chk("stall2 in_ready", 64'(snap_ready[0]), 64'd0);
      chk("stall2 valid", 64'(snap_valid[0]), 64'd1);
      chk("stall2 chosen", 64'(snap_chosen[0]), 64'(hold_ch));
    end

    // Reset in the middle of a channel-3 message.
    drive(4'b1000, 4'b1000, 1'b1);
    step();
    drive(4'b1000, 4'b0000, 1'b1);
    step();
    chk("pre-reset locked", 64'(snap_locked[0]), 64'd1);
    pulse_reset();
    drive(4'b1111, 4'b0000, 1'b1);
    step();
    chk("post-reset chosen", 64'(snap_chosen[0]), 64'd0);
    chk("post-reset locked", 64'(snap_locked[0]), 64'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        drive(N'($urandom), N'($urandom & $urandom), ($urandom_range(0, 3) != 0));
        step();
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
